// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and channel bundles shared by the crossbar,
// the arbiters and the slave-side responders.
package tl_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  mask;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [31:0] data;
        logic        denied;
    } tl_d_t;

endpackage

// File: rtl/tl_sram_array.sv
// DEPTH x 32 single-port synchronous SRAM with byte enables and one-cycle
// read latency. Contents are not reset and survive a bus reset.
module tl_sram_array #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/tl_sram_responder.sv
// TileLink-UL slave endpoint serving Get/PutFullData from an internal SRAM,
// one transaction in flight, response registered one cycle after A fires.
module tl_sram_responder
    import tl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_a_valid,
    output logic        io_a_ready,
    input  logic [2:0]  io_a_bits_opcode,
    input  logic [31:0] io_a_bits_address,
    input  logic [31:0] io_a_bits_data,
    input  logic [3:0]  io_a_bits_mask,
    output logic        io_d_valid,
    input  logic        io_d_ready,
    output logic [2:0]  io_d_bits_opcode,
    output logic [31:0] io_d_bits_data,
    output logic        io_d_bits_denied
);

    localparam int          IW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    state_t      state;
    tl_a_t       a;
    tl_d_t       d;
    logic [31:0] offset;
    logic        hit, is_get, is_put, fire, mem_en;
    logic [31:0] rdata;
    logic        a_ready_q, d_valid_q, d_denied_q, d_read_q;
    logic [2:0]  d_opcode_q;

    assign a = '{opcode: io_a_bits_opcode, address: io_a_bits_address,
                 data: io_a_bits_data, mask: io_a_bits_mask};

    // Offset compare cannot overflow at the top of the address space.
    assign offset = a.address - BASE_ADDR;
    assign hit    = offset < WIN_BYTES;
    assign is_get = a.opcode == GET;
    assign is_put = a.opcode == PUT_FULL;
    assign fire   = io_a_valid && (state == IDLE);
    assign mem_en = fire && hit && (is_get || is_put);

    tl_sram_array #(.DEPTH(DEPTH), .IW(IW)) u_array (
        .clock (clock),
        .en    (mem_en),
        .we    (is_put),
        .be    (a.mask),
        .addr  (offset[IW+1:2]),
        .wdata (a.data),
        .rdata (rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_ready_q  <= 1'b1;
            d_valid_q  <= 1'b0;
            d_opcode_q <= ACCESS_ACK;
            d_denied_q <= 1'b0;
            d_read_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_a_valid) begin
                        state      <= RESP;
                        a_ready_q  <= 1'b0;
                        d_valid_q  <= 1'b1;
                        d_opcode_q <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                        d_denied_q <= !(hit && (is_get || is_put));
                        d_read_q   <= hit && is_get;
                    end
                end
                RESP: begin
                    if (io_d_ready) begin
                        state     <= IDLE;
                        a_ready_q <= 1'b1;
                        d_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array output register doubles as the D data register; it only
    // updates on a read, so it holds steady while the response is stalled.
    assign d = '{opcode: d_opcode_q, data: d_read_q ? rdata : 32'h0,
                 denied: d_denied_q};

    assign io_a_ready       = a_ready_q;
    assign io_d_valid       = d_valid_q;
    assign io_d_bits_opcode = d.opcode;
    assign io_d_bits_data   = d.data;
    assign io_d_bits_denied = d.denied;

endmodule

// File: doc/tl_sram_responder.md
# tl_sram_responder

TileLink-UL responder (slave end) that terminates one crossbar slave port and serves it from an internal word-addressed SRAM. It accepts A-channel Get/PutFullData requests from the bus, performs the access, and returns AccessAckData/AccessAck on the D channel. One transaction is in flight at a time. It sits behind the bus crossbar's slave port 0, in the 0x0000–0x0FFF address window.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, first byte address served
- DEPTH, 1024, number of 32-bit words; the window is [BASE_ADDR, BASE_ADDR+4*DEPTH)

Ports:
- clock  in  1  single clock for all state
- reset  in  1  asynchronous, active-high
- io_a_valid  in  1  request valid
- io_a_ready  out  1  request accepted when valid&ready
- io_a_bits_opcode  in  3  0=PutFullData, 4=Get, all others unsupported
- io_a_bits_address  in  32  byte address; bits[1:0] ignored
- io_a_bits_data  in  32  write data
- io_a_bits_mask  in  4  byte enables for Put
- io_d_valid  out  1  response valid
- io_d_ready  in  1  response consumed when valid&ready
- io_d_bits_opcode  out  3  1=AccessAckData, 0=AccessAck
- io_d_bits_data  out  32  read data; 0 for AccessAck
- io_d_bits_denied  out  1  request was out of range or unsupported

## Operation
- FSM states: IDLE, RESP.
- IDLE: io_a_ready=1 and io_d_valid=0. An A fire computes hit = (BASE_ADDR <= addr < BASE_ADDR+4*DEPTH), index = (addr-BASE_ADDR)[log2(4*DEPTH)-1:2], and sets the next state to RESP.
  - Get with hit: the array read issues in the fire cycle. Response is AccessAckData with the array data and denied=0.
  - PutFullData with hit: bytes where mask[i]=1 are written in the fire cycle and the other bytes are unchanged. Response is AccessAck with data=0 and denied=0. A mask of 0 writes nothing and still acks.
  - Miss or unsupported opcode: there is no array access. Response has denied=1 and data=0. Opcode is AccessAckData for a Get and AccessAck for all other opcodes.
- RESP: io_a_ready=0, and io_d_valid=1 with the D bits held stable. When io_d_ready=1, the response fires and the state returns to IDLE.
- A Put followed by a Get to the same word returns the written bytes. There is no forwarding hazard, because only one transaction is in flight.
- The array has no reset, and its contents are retained across reset.
- Address arithmetic is 32-bit unsigned. The window-end compare must not overflow: compute it as addr - BASE_ADDR < 4*DEPTH.

## Timing
- Reset (asynchronous assert) puts the state in IDLE and gives io_a_ready=1, io_d_valid=0, io_d_bits_opcode=0, io_d_bits_data=0, io_d_bits_denied=0. Deassertion is synchronous to clock.
- Latency: A fire at cycle N gives io_d_valid=1 at cycle N+1.
- The D bits come from registers, with read data captured at N+1 from the synchronous array. They do not change while io_d_valid=1 and io_d_ready=0.
- Throughput is at best one transaction per 2 cycles. io_a_ready is 0 throughout RESP, including the D fire cycle. The next request is accepted no earlier than the cycle after D fires.
- io_a_ready does not depend combinationally on io_a_valid. io_d_valid does not depend combinationally on io_d_ready.
- Reset mid-transaction drops the pending response, and the state goes to IDLE. A Put already accepted has already written the array.

## Structure
- Shared package tl_pkg holds:
  - the opcode constants PUT_FULL=0, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1;
  - the A and D channel bundle typedefs, shared with the crossbar and the arbiters.
- One sub-module, tl_sram_array: DEPTH×32 storage with a single synchronous read/write port, a 4-bit byte-enable write, and a 1-cycle read latency.
- The top level holds the FSM, the address decode and the D-channel registers.

## Test plan
- Reset check: assert reset asynchronously mid-cycle, then release it. Required: io_a_ready=1, io_d_valid=0, all D bits 0.
- Put/Get roundtrip:
  - Put addr 0x0010, data 0xDEADBEEF, mask 0xF, with io_d_ready=1. Required: io_d_valid=1 one cycle after the fire, opcode 0, denied 0.
  - Then Get addr 0x0012. Required: opcode 1, data 0xDEADBEEF.
- Partial mask: with the word at 0x0010 holding 0xDEADBEEF, Put data 0x11223344 with mask 0x5, then Get. Required: data 0xDE22BE44.
- Backpressure: Get with io_d_ready=0 for 5 cycles. Required: io_d_valid stays 1 with data stable, io_a_ready=0 throughout, and a new io_a_valid is not accepted. Fire with io_d_ready=1, then require io_a_ready=1 on the next cycle.
- Denied requests:
  - Get addr 0x1000. Required: opcode 1, denied 1, data 0.
  - Opcode 2 to addr 0x0010. Required: opcode 0, denied 1, and a following Get of 0x0010 shows the word unchanged.
- Reset during RESP: issue a Put to 0x0020, then assert reset while io_d_valid=1. Required: io_d_valid=0 immediately. After release, a Get of 0x0020 returns the written data.
